// File: rtl/ray_tracing_pkg.sv
// ray_tracing_pkg
//   Shared constants and types for the fixed-point ray-tracing datapath.
//   Vectors are packed {x, y, z}. Each component is sign-magnitude: the top bit
//   is the sign (1 = negative) and the remaining bits are an unsigned magnitude
//   with FRAC_BITS fractional bits.
package ray_tracing_pkg;

  localparam int VECTOR_WIDTH = 57;
  localparam int COMP_WIDTH   = 19;
  localparam int FRAC_BITS    = 10;

  // Largest representable component magnitude (Q8.10, all ones).
  localparam logic [17:0] MAG_MAX = 18'h3FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } dot_state_e;

endpackage

// File: rtl/sign_magnitude_multiplier.sv
// sign_magnitude_multiplier
//   Combinational sign-magnitude fixed-point multiply. The full magnitude
//   product is shifted right by FRAC_BITS (truncation) so the result keeps the
//   operands' fixed-point scaling.
//   Ports:
//     a_i, b_i : COMP_WIDTH-bit sign-magnitude operands
//     sign_o   : product sign, forced to 0 when the magnitude is zero
//     mag_o    : truncated product magnitude, 2*(COMP_WIDTH-1)-FRAC_BITS bits
module sign_magnitude_multiplier #(
  parameter int COMP_WIDTH = 19,
  parameter int FRAC_BITS  = 10
) (
  input  logic [COMP_WIDTH-1:0]                   a_i,
  input  logic [COMP_WIDTH-1:0]                   b_i,
  output logic                                    sign_o,
  output logic [2*(COMP_WIDTH-1)-FRAC_BITS-1:0]   mag_o
);

  localparam int MAG_W = COMP_WIDTH - 1;

  logic [2*MAG_W-1:0] full_prod;

  assign full_prod = {{MAG_W{1'b0}}, a_i[MAG_W-1:0]} * {{MAG_W{1'b0}}, b_i[MAG_W-1:0]};
  assign mag_o     = full_prod[2*MAG_W-1:FRAC_BITS];
  // A -0 operand, or a product truncated to zero, must not yield a negative zero.
  assign sign_o    = (a_i[COMP_WIDTH-1] ^ b_i[COMP_WIDTH-1]) & (|mag_o);

endmodule

// File: rtl/signed_vector_dot_product.sv
// signed_vector_dot_product
//   Sequential 3-component dot product of two sign-magnitude vectors. One
//   component is multiplied and accumulated per cycle (x, y, z); the
//   two's-complement sum is converted back to saturated sign-magnitude.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     in_valid / in_ready      : operand handshake (ready only when idle)
//     in_vector_1, in_vector_2 : packed {x, y, z} operands
//     out_valid / out_ready    : result handshake (valid only when done)
//     out_scalar               : {sign, magnitude} result, Q8.10
//     out_sat                  : result magnitude was clamped
module signed_vector_dot_product #(
  parameter int VECTOR_WIDTH = ray_tracing_pkg::VECTOR_WIDTH,
  parameter int COMP_WIDTH   = ray_tracing_pkg::COMP_WIDTH,
  parameter int FRAC_BITS    = ray_tracing_pkg::FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VECTOR_WIDTH-1:0] in_vector_1,
  input  logic [VECTOR_WIDTH-1:0] in_vector_2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COMP_WIDTH-1:0]   out_scalar,
  output logic                    out_sat
);

  import ray_tracing_pkg::dot_state_e;
  import ray_tracing_pkg::IDLE;
  import ray_tracing_pkg::MUL;
  import ray_tracing_pkg::DONE;
  import ray_tracing_pkg::MAG_MAX;

  localparam int MAG_W  = COMP_WIDTH - 1;
  localparam int PROD_W = 2 * MAG_W - FRAC_BITS;
  // Three terms of PROD_W bits need two growth bits plus a sign bit.
  localparam int ACC_W  = PROD_W + 3;

  dot_state_e state_q, state_d;

  logic [VECTOR_WIDTH-1:0]  a_q, b_q;
  logic [1:0]               idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [COMP_WIDTH-1:0]    scalar_q;
  logic                     sat_q;

  logic                     accept;
  logic [COMP_WIDTH-1:0]    comp_a, comp_b;
  logic                     prod_sign;
  logic [PROD_W-1:0]        prod_mag;
  logic signed [ACC_W-1:0]  term_s;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [COMP_WIDTH:0]      final_res;

  // Converts the accumulator to {sat, sign, magnitude}. Zero is never negative
  // because a zero accumulator has its sign bit clear.
  function automatic logic [COMP_WIDTH:0] sat_to_sign_mag(input logic signed [ACC_W-1:0] acc);
    logic [ACC_W-1:0] abs_v;
    logic [MAG_W-1:0] mag;
    logic             sat;
    abs_v = acc[ACC_W-1] ? $unsigned(-acc) : $unsigned(acc);
    sat   = abs_v > ACC_W'(MAG_MAX);
    mag   = sat ? MAG_W'(MAG_MAX) : abs_v[MAG_W-1:0];
    return {sat, acc[ACC_W-1], mag};
  endfunction

  assign accept = in_valid && (state_q == IDLE);

  // Component select: index 0 is x (most significant field).
  always_comb begin
    comp_a = a_q[COMP_WIDTH-1:0];
    comp_b = b_q[COMP_WIDTH-1:0];
    case (idx_q)
      2'd0: begin
        comp_a = a_q[VECTOR_WIDTH-1 -: COMP_WIDTH];
        comp_b = b_q[VECTOR_WIDTH-1 -: COMP_WIDTH];
      end
      2'd1: begin
        comp_a = a_q[2*COMP_WIDTH-1 -: COMP_WIDTH];
        comp_b = b_q[2*COMP_WIDTH-1 -: COMP_WIDTH];
      end
      default: ;
    endcase
  end

  sign_magnitude_multiplier #(
    .COMP_WIDTH (COMP_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mul (
    .a_i    (comp_a),
    .b_i    (comp_b),
    .sign_o (prod_sign),
    .mag_o  (prod_mag)
  );

  assign term_s    = prod_sign ? -$signed({3'b000, prod_mag}) : $signed({3'b000, prod_mag});
  assign acc_sum   = acc_q + term_s;
  assign final_res = sat_to_sign_mag(acc_sum);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)       state_d = MUL;
      MUL:     if (idx_q == 2'd2)  state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operand capture: data only, loaded solely on the accepting edge so later
  // input changes cannot disturb an in-flight computation.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_vector_1;
      b_q <= in_vector_2;
    end
  end

  // Accumulate / result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      idx_q    <= 2'd0;
      scalar_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q <= '0;
            idx_q <= 2'd0;
          end
        end
        MUL: begin
          acc_q <= acc_sum;
          if (idx_q == 2'd2) begin
            idx_q    <= 2'd0;
            scalar_q <= final_res[COMP_WIDTH-1:0];
            sat_q    <= final_res[COMP_WIDTH];
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_scalar = scalar_q;
  assign out_sat    = sat_q;

endmodule

// File: tb/tb_signed_vector_dot_product.sv
// tb_signed_vector_dot_product
//   Directed and randomized checks of the sign-magnitude dot product against
//   spec constants and an integer reference model.
module tb_signed_vector_dot_product;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [56:0] in_vector_1;
  logic [56:0] in_vector_2;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_scalar;
  logic        out_sat;

  int checks = 0;
  int errors = 0;

  signed_vector_dot_product dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vector_1 (in_vector_1),
    .in_vector_2 (in_vector_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_scalar  (out_scalar),
    .out_sat     (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed Q10 integer -> 19-bit sign-magnitude component.
  function automatic logic [18:0] sm(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return {(v < 0) ? 1'b1 : 1'b0, m[17:0]};
  endfunction

  function automatic logic [56:0] vec(input int x, input int y, input int z);
    return {sm(x), sm(y), sm(z)};
  endfunction

  function automatic logic [56:0] rand_vec();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[56:0];
  endfunction

  // Reference: real-valued dot product in Q10 integers, each product truncated
  // toward zero on its magnitude, then clamped to the 18-bit magnitude range.
  function automatic void ref_dot(input logic [56:0] a, input logic [56:0] b,
                                  output logic [18:0] scal, output logic sat);
    longint acc;
    longint p;
    longint mag;
    logic [18:0] ca, cb;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      ca = a[56 - 19*i -: 19];
      cb = b[56 - 19*i -: 19];
      p  = (longint'(ca[17:0]) * longint'(cb[17:0])) / 1024;
      if (ca[18] != cb[18]) acc = acc - p;
      else                  acc = acc + p;
    end
    mag = (acc < 0) ? -acc : acc;
    sat = (mag > 262143);
    if (sat) mag = 262143;
    scal = {(acc < 0) ? 1'b1 : 1'b0, mag[17:0]};
  endfunction

  // One full transaction from IDLE. hold = cycles out_ready stays low in DONE.
  task automatic do_op(input logic [56:0] a, input logic [56:0] b,
                       input logic [18:0] exp_s, input logic exp_sat,
                       input int hold, input string tag);
    chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    in_vector_1 = a;
    in_vector_2 = b;
    in_valid    = 1'b1;
    out_ready   = (hold == 0);
    tick();
    chk({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
    for (int c = 1; c <= 3; c++) begin
      // Junk on the inputs while busy must be ignored.
      in_valid    = 1'($urandom_range(0, 1));
      in_vector_1 = rand_vec();
      in_vector_2 = rand_vec();
      chk({tag, " out_valid_early"}, 64'(out_valid), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk({tag, " out_valid_lat3"}, 64'(out_valid), 64'd1);
    chk({tag, " out_scalar"}, 64'(out_scalar), 64'(exp_s));
    chk({tag, " out_sat"}, 64'(out_sat), 64'(exp_sat));
    for (int h = 0; h < hold; h++) begin
      in_valid    = 1'b1;
      in_vector_1 = rand_vec();
      in_vector_2 = rand_vec();
      tick();
      chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, " hold_scalar"}, 64'(out_scalar), 64'(exp_s));
      chk({tag, " hold_sat"}, 64'(out_sat), 64'(exp_sat));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk({tag, " release_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " release_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [56:0] ra, rb;
    logic [18:0] es;
    logic        esat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_vector_1 = '0; in_vector_2 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_scalar", 64'(out_scalar), 64'd0);
    chk("reset out_sat", 64'(out_sat), 64'd0);

    // (1,2,3).(4,5,6) = 32.0
    do_op(vec(1024, 2048, 3072), vec(4096, 5120, 6144), {1'b0, 18'h08000}, 1'b0, 0, "dot123_456");
    do_op(vec(-1024, 0, 0), vec(2048, 0, 0), {1'b1, 18'h00800}, 1'b0, 0, "neg1x2");
    do_op(vec(-1024, 0, 0), vec(-1024, 0, 0), {1'b0, 18'h00400}, 1'b0, 0, "neg1xneg1");
    do_op(vec(1024, 1024, 0), vec(-1024, 1024, 0), {1'b0, 18'h00000}, 1'b0, 0, "cancel_zero");
    do_op(vec(204800, 204800, 204800), vec(204800, 204800, 204800), {1'b0, 18'h3FFFF}, 1'b1, 0, "sat_pos");
    do_op(vec(204800, 204800, 204800), vec(-204800, -204800, -204800), {1'b1, 18'h3FFFF}, 1'b1, 0, "sat_neg");
    do_op(vec(512, 0, 0), vec(512, 0, 0), {1'b0, 18'h00100}, 1'b0, 0, "trunc_half");
    do_op(vec(1, 0, 0), vec(1, 0, 0), {1'b0, 18'h00000}, 1'b0, 0, "trunc_lsb");
    do_op({1'b1, 18'h0, sm(0), sm(0)}, vec(1024, 0, 0), {1'b0, 18'h00000}, 1'b0, 0, "neg_zero");
    do_op(vec(-3, 0, 0), vec(1000, 0, 0), {1'b1, 18'h00002}, 1'b0, 0, "trunc_neg");

    // Backpressure: six cycles of out_ready low with in_valid and new operands.
    do_op(vec(1024, 2048, 3072), vec(4096, 5120, 6144), {1'b0, 18'h08000}, 1'b0, 6, "backpressure");
    tick();
    chk("bp no_accept", 64'(out_valid), 64'd0);

    // Reset in the middle of MUL (index 1).
    in_vector_1 = vec(204800, 204800, 204800);
    in_vector_2 = vec(204800, 204800, 204800);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst out_scalar", 64'(out_scalar), 64'd0);
    chk("midrst out_sat", 64'(out_sat), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst no_ghost", 64'(out_valid), 64'd0);
    end
    do_op(vec(-1024, 0, 0), vec(2048, 0, 0), {1'b1, 18'h00800}, 1'b0, 0, "after_rst");

    // Randomized operands checked against the reference model.
    for (int n = 0; n < 60; n++) begin
      ra = rand_vec();
      rb = rand_vec();
      if (n % 3 == 0) begin
        // Small magnitudes to exercise non-saturating sums and cancellation.
        for (int k = 0; k < 3; k++) begin
          ra[56 - 19*k -: 19] = {ra[56 - 19*k], 8'd0, ra[46 - 19*k -: 10]};
          rb[56 - 19*k -: 19] = {rb[56 - 19*k], 6'd0, rb[44 - 19*k -: 12]};
        end
      end
      ref_dot(ra, rb, es, esat);
      do_op(ra, rb, es, esat, int'($urandom_range(0, 2)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_vector_dot_product.md
SIGNED_VECTOR_DOT_PRODUCT -- requirements
Module: signed_vector_dot_product

Interface
REQ-001 Parameters SHALL be: VECTOR_WIDTH, default 57, packed {x,y,z} width; COMP_WIDTH, default 19, per-component width; FRAC_BITS, default 10, fractional bits.
REQ-002 Ports SHALL be: clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in_vector_1  input  57  operand A {x[56:38], y[37:19], z[18:0]}.
REQ-007 in_vector_2  input  57  operand B, same packing.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_scalar  output  19  A·B as {sign, magnitude[17:0]}, Q8.10.
REQ-011 out_sat  output  1  result was saturated.

Function
REQ-012 Components SHALL be sign-magnitude: bit 18 sign (1 = negative), bits 17:0 magnitude with 10 fractional bits; magnitude 0 with sign 1 SHALL be treated as +0.
REQ-013 FSM states SHALL be IDLE, MUL, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE: on in_valid && in_ready, both operands SHALL be latched, accumulator cleared, component index set to 0, state -> MUL.
REQ-015 MUL: one component per cycle in order x, y, z (index 0,1,2); each cycle term = (mag1*mag2) >> 10, truncated, 26-bit magnitude, sign = s1 XOR s2; term is added to or subtracted from a 29-bit two's-complement accumulator.
REQ-016 The edge processing z SHALL also register out_scalar and out_sat and move state -> DONE; out_valid is high 3 cycles after the accepting edge.
REQ-017 Final conversion: sign = accumulator negative; magnitude = |acc|; if |acc| > 18'h3FFFF then magnitude = 18'h3FFFF and out_sat = 1, else out_sat = 0; a zero result SHALL carry sign 0.
REQ-018 DONE: out_scalar and out_sat SHALL hold stable while out_ready = 0; on out_ready = 1 state -> IDLE; in_ready rises the following cycle (no same-cycle bypass).
REQ-019 in_vector_1/2 changes outside the accepting cycle SHALL NOT affect an in-flight computation.
REQ-020 in_valid during MUL or DONE SHALL be ignored (not accepted, not queued).
REQ-021 Throughput SHALL be one result per 5 cycles minimum with out_ready held high.

Reset
REQ-022 rst SHALL take priority over all other inputs, including mid-MUL and mid-DONE, and force state IDLE.
REQ-023 After reset: in_ready = 1, out_valid = 0, out_scalar = 19'h0, out_sat = 0, accumulator = 0, index = 0; a discarded in-flight result SHALL never appear on out_valid.

Structure
REQ-024 VECTOR_WIDTH, COMP_WIDTH, FRAC_BITS, MAG_MAX (18'h3FFFF) and the FSM state enum SHALL live in shared package ray_tracing_pkg.
REQ-025 One sub-module SHALL be instantiated: sign_magnitude_multiplier (combinational, 19b x 19b sign-magnitude -> sign + truncated 26-bit magnitude), reused by later shading stages.

Verification
REQ-026 (1,2,3)·(4,5,6), i.e. x/y/z mags 0x00400/0x00800/0x00C00 and 0x01000/0x01400/0x01800 -> out_scalar = {0, 18'h08000} (32.0), out_sat = 0, out_valid 3 cycles after accept.
REQ-027 (-1,0,0)·(2,0,0) -> {1, 18'h00800} (-2.0); (-1,0,0)·(-1,0,0) -> {0, 18'h00400}; (1,0,0)·(-1,0,0) + (0,1,0)·(0,1,0) in one vector pair (A=(1,1,0), B=(-1,1,0)) -> {0, 18'h0} with sign 0.
REQ-028 (200,200,200)·(200,200,200) (mag 0x32000 each) -> {0, 18'h3FFFF}, out_sat = 1; same with B negated -> {1, 18'h3FFFF}, out_sat = 1.
REQ-029 Truncation: (0.5,0,0)·(0.5,0,0) -> mag 0x00100; (1/1024,0,0)·(1/1024,0,0) -> mag 0, sign 0.
REQ-030 Backpressure: hold out_ready = 0 for 6 cycles in DONE with in_valid = 1 and changing operands -> out_scalar stable, in_ready = 0, nothing accepted; release -> one transfer, in_ready = 1 next cycle.
REQ-031 Assert rst one cycle during MUL (index 1) -> next cycle all REQ-023 values; no out_valid for the aborted operation; new operation then completes correctly.
